// File: rtl/affine_pkg.sv
// Shared types and helpers for the affine I/O engine: FSM state encoding, product count,
// and the saturate/wrap rule applied to rounded results.
package affine_pkg;

   typedef enum logic [2:0] {
      StWaitX,
      StRelX,
      StWaitY,
      StRelY,
      StCompute,
      StRound,
      StShowX,
      StShowY
   } state_e;

   localparam int unsigned NPROD = 4;

   // Clamp r to the signed w-bit range when sat is set; otherwise pass it through so the
   // caller's truncation to w bits gives two's-complement wrap.
   function automatic logic [31:0] sat_w(input longint r, input int unsigned w, input bit sat);
      longint hi;
      longint lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      if (sat && (r > hi)) return 32'(hi);
      if (sat && (r < lo)) return 32'(lo);
      return 32'(r);
   endfunction

endpackage

// File: rtl/serial_mult_s.sv
// Signed W x W shift-add multiplier. One multiplier bit per cycle; the product is
// presented combinationally with valid in the W-th cycle counted from start.
module serial_mult_s #(
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] prod,
   output logic           valid
);

   localparam int unsigned CW = $clog2(W) + 1;

   logic signed [2*W-1:0] a_ext;
   logic signed [2*W-1:0] mcand_q;
   logic signed [2*W-1:0] acc_q;
   logic signed [2*W-1:0] term;
   logic signed [2*W-1:0] sum;
   logic [W-1:0]          mplier_q;
   logic [CW-1:0]         cnt_q;
   logic                  run_q;
   logic                  last;

   assign a_ext = {{W{a[W-1]}}, a};
   assign last  = run_q && (cnt_q == CW'(W - 1));

   // The multiplier MSB carries weight -2^(W-1), so its partial product is subtracted.
   always_comb begin
      term = '0;
      if (mplier_q[0]) begin
         term = (cnt_q == CW'(W - 1)) ? -mcand_q : mcand_q;
      end
      sum = acc_q + term;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start) begin
         acc_q    <= b[0] ? a_ext : '0;
         mcand_q  <= a_ext << 1;
         mplier_q <= b >> 1;
         cnt_q    <= CW'(1);
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q    <= sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (last) begin
            run_q <= 1'b0;
         end
      end
   end

   assign prod  = sum;
   assign valid = last;

endmodule

// File: rtl/affine_io_engine.sv
// Button-driven affine transform: captures (x1, y1) from the switches, computes
// x2/y2 on one shared serial multiplier, then shows x2 and y2 on the LEDs.
module affine_io_engine
   import affine_pkg::*;
#(
   parameter int unsigned W    = 8,
   parameter int unsigned FRAC = W - 1,
   parameter int          A11  = 96,
   parameter int          A12  = 64,
   parameter int          A21  = -64,
   parameter int          A22  = 96,
   parameter int          B1   = 20,
   parameter int          B2   = -20,
   parameter bit          SAT  = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Bstus,
   input  logic [W-1:0] x,
   output logic [W-1:0] outport,
   output logic         busy,
   output logic         done
);

   localparam int unsigned CW = $clog2(W) + 1;

   state_e state_q, state_d;

   logic                  sync1_q;
   logic                  btn_s;
   logic [W-1:0]          x1_q;
   logic [W-1:0]          y1_q;
   logic [W-1:0]          last_q;
   logic [W-1:0]          x2_q;
   logic [W-1:0]          y2_q;
   logic [CW-1:0]         phase_q, phase_d;
   logic [1:0]            idx_q, idx_d;
   logic signed [2*W:0]   acc1_q, acc1_d;
   logic signed [2*W:0]   acc2_q, acc2_d;
   logic                  done_q;
   logic                  last_phase;
   logic                  mult_start;
   logic                  mult_valid;
   logic [W-1:0]          mult_a;
   logic [W-1:0]          mult_b;
   logic signed [2*W-1:0] prod;
   logic signed [2*W:0]   prod_ext;
   longint                r1;
   longint                r2;

   serial_mult_s #(
      .W (W)
   ) u_mult (
      .clk   (clk),
      .reset (reset),
      .start (mult_start),
      .a     (mult_a),
      .b     (mult_b),
      .prod  (prod),
      .valid (mult_valid)
   );

   assign prod_ext   = {prod[2*W-1], prod};
   assign last_phase = (phase_q == CW'(W - 1));

   // Product order: A11*X1, A12*Y1, A21*X1, A22*Y1.
   always_comb begin
      unique case (idx_q)
         2'd0:    mult_a = W'(A11);
         2'd1:    mult_a = W'(A12);
         2'd2:    mult_a = W'(A21);
         default: mult_a = W'(A22);
      endcase
      mult_b = idx_q[0] ? y1_q : x1_q;
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = '0;
      idx_d      = '0;
      acc1_d     = acc1_q;
      acc2_d     = acc2_q;
      mult_start = 1'b0;

      unique case (state_q)
         StWaitX: if (btn_s)  state_d = StRelX;
         StRelX:  if (!btn_s) state_d = StWaitY;
         StWaitY: if (btn_s)  state_d = StRelY;
         StRelY:  if (!btn_s) state_d = StCompute;
         StCompute: begin
            // A new product starts every W cycles, right after the previous valid.
            mult_start = (phase_q == '0);
            phase_d    = last_phase ? '0 : phase_q + 1'b1;
            idx_d      = last_phase ? idx_q + 1'b1 : idx_q;
            if (last_phase && (idx_q == 2'(NPROD - 1))) begin
               state_d = StRound;
            end
         end
         StRound: state_d = StShowX;
         StShowX: if (btn_s)  state_d = StShowY;
         StShowY: if (!btn_s) state_d = StWaitX;
         default: state_d = StWaitX;
      endcase

      if (mult_valid) begin
         unique case (idx_q)
            2'd0:    acc1_d = prod_ext;
            2'd1:    acc1_d = acc1_q + prod_ext;
            2'd2:    acc2_d = prod_ext;
            default: acc2_d = acc2_q + prod_ext;
         endcase
      end
   end

   // Arithmetic shift floors toward -inf; 64-bit arithmetic keeps the offset add exact.
   always_comb begin
      r1 = (longint'(acc1_q) >>> FRAC) + longint'(B1);
      r2 = (longint'(acc2_q) >>> FRAC) + longint'(B2);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StWaitX;
         sync1_q <= 1'b0;
         btn_s   <= 1'b0;
         x1_q    <= '0;
         y1_q    <= '0;
         last_q  <= '0;
         x2_q    <= '0;
         y2_q    <= '0;
         phase_q <= '0;
         idx_q   <= '0;
         acc1_q  <= '0;
         acc2_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         sync1_q <= Bstus;
         btn_s   <= sync1_q;
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         acc1_q  <= acc1_d;
         acc2_q  <= acc2_d;
         done_q  <= (state_q == StRound);
         if ((state_q == StWaitX) && btn_s) begin
            x1_q   <= x;
            last_q <= x;
         end
         if ((state_q == StWaitY) && btn_s) begin
            y1_q   <= x;
            last_q <= x;
         end
         if (state_q == StRound) begin
            x2_q <= W'(sat_w(r1, W, SAT));
            y2_q <= W'(sat_w(r2, W, SAT));
         end
      end
   end

   always_comb begin
      unique case (state_q)
         StShowX: outport = x2_q;
         StShowY: outport = y2_q;
         default: outport = last_q;
      endcase
   end

   assign busy = (state_q == StCompute) || (state_q == StRound);
   assign done = done_q;

endmodule

// File: tb/tb_affine_io_engine.sv
// Directed-plus-random bench for affine_io_engine: saturating, wrapping and 12-bit
// instances driven by one shared button/switch sequence and checked against a math model.
module tb_affine_io_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        Bstus;
   logic [7:0]  x;
   logic [11:0] x12;
   logic [7:0]  out_s;
   logic [7:0]  out_w;
   logic [11:0] out_12;
   logic        busy_s, busy_w, busy_12;
   logic        done_s, done_w, done_12;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   affine_io_engine dut_s (
      .clk     (clk),
      .reset   (reset),
      .Bstus   (Bstus),
      .x       (x),
      .outport (out_s),
      .busy    (busy_s),
      .done    (done_s)
   );

   affine_io_engine #(
      .SAT (1'b0)
   ) dut_w (
      .clk     (clk),
      .reset   (reset),
      .Bstus   (Bstus),
      .x       (x),
      .outport (out_w),
      .busy    (busy_w),
      .done    (done_w)
   );

   affine_io_engine #(
      .W    (12),
      .FRAC (11),
      .A11  (1536),
      .A12  (1024),
      .A21  (-1024),
      .A22  (1536),
      .B1   (20),
      .B2   (-20),
      .SAT  (1'b1)
   ) dut_12 (
      .clk     (clk),
      .reset   (reset),
      .Bstus   (Bstus),
      .x       (x12),
      .outport (out_12),
      .busy    (busy_12),
      .done    (done_12)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // floor(c1*xa + c2*xb / 2^frac) + b, then clamp or wrap to w bits.
   function automatic logic [31:0] ref_out(input longint c1, input longint c2, input longint b,
                                           input longint xa, input longint xb, input int w,
                                           input int frac, input bit sat);
      longint p, d, q, hi;
      p = c1 * xa + c2 * xb;
      d = longint'(1) << frac;
      q = p / d;
      if ((p < 0) && ((p % d) != 0)) q = q - 1;
      q = q + b;
      hi = (longint'(1) << (w - 1)) - 1;
      if (sat && (q > hi)) q = hi;
      if (sat && (q < -hi - 1)) q = -hi - 1;
      return 32'(q & ((longint'(1) << w) - 1));
   endfunction

   // cfg 0: saturating 8-bit, 1: wrapping 8-bit, 2: saturating 12-bit with scaled coefficients
   function automatic logic [31:0] ref_xy(input int cfg, input bit is_y, input int xa, input int xb);
      int w, frac, sc;
      bit sat;
      w    = (cfg == 2) ? 12 : 8;
      frac = w - 1;
      sc   = (cfg == 2) ? 16 : 1;
      sat  = (cfg != 1);
      if (is_y) return ref_out(-64 * sc, 96 * sc, -20, xa, xb, w, frac, sat);
      return ref_out(96 * sc, 64 * sc, 20, xa, xb, w, frac, sat);
   endfunction

   task automatic drive_x(input int v);
      x   = 8'(v);
      x12 = 12'(v);
   endtask

   task automatic check_mirror(input string tag, input int v);
      check({tag, "_s"}, 32'(out_s), 32'(v) & 32'hFF);
      check({tag, "_w"}, 32'(out_w), 32'(v) & 32'hFF);
      check({tag, "_12"}, 32'(out_12), 32'(v) & 32'hFFF);
   endtask

   task automatic capture_x(input int v);
      drive_x(v);
      Bstus = 1'b1;
      tick(4);
      check_mirror("cap_x", v);
      Bstus = 1'b0;
      tick(4);
   endtask

   task automatic wait_busy(output bit found);
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (busy_s === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("busy_rise", 32'(found), 32'd1);
   endtask

   task automatic finish_point(input int xa, input int xb);
      bit found;
      drive_x(xb);
      Bstus = 1'b1;
      tick(4);
      check_mirror("cap_y", xb);
      Bstus = 1'b0;
      wait_busy(found);
      tick(32);
      check("round_busy", 32'(busy_s), 32'd1);
      check("round_no_done", 32'(done_s), 32'd0);
      tick(1);
      check("showx_busy", 32'(busy_s), 32'd0);
      check("showx_done_s", 32'(done_s), 32'd1);
      check("showx_done_w", 32'(done_w), 32'd1);
      check("x2_sat", 32'(out_s), ref_xy(0, 1'b0, xa, xb));
      check("x2_wrap", 32'(out_w), ref_xy(1, 1'b0, xa, xb));
      check("w12_still_busy", 32'(busy_12), 32'd1);
      tick(1);
      check("done_one_cycle", 32'(done_s), 32'd0);
      check("x2_hold", 32'(out_s), ref_xy(0, 1'b0, xa, xb));
      tick(15);
      check("showx_done_12", 32'(done_12), 32'd1);
      check("x2_w12", 32'(out_12), ref_xy(2, 1'b0, xa, xb));
      Bstus = 1'b1;
      tick(4);
      check("y2_sat", 32'(out_s), ref_xy(0, 1'b1, xa, xb));
      check("y2_wrap", 32'(out_w), ref_xy(1, 1'b1, xa, xb));
      check("y2_w12", 32'(out_12), ref_xy(2, 1'b1, xa, xb));
      Bstus = 1'b0;
      tick(4);
      check_mirror("back_wait_x", xb);
   endtask

   task automatic run_point(input int xa, input int xb);
      capture_x(xa);
      finish_point(xa, xb);
   endtask

   initial begin
      int  vals[21];
      int  dones;
      bit  found;

      reset = 1'b1;
      Bstus = 1'b0;
      drive_x(0);
      tick(3);
      check("rst_out_s", 32'(out_s), 32'd0);
      check("rst_out_w", 32'(out_w), 32'd0);
      check("rst_out_12", 32'(out_12), 32'd0);
      check("rst_busy_s", 32'(busy_s), 32'd0);
      check("rst_busy_12", 32'(busy_12), 32'd0);
      check("rst_done_s", 32'(done_s), 32'd0);
      check("rst_done_12", 32'(done_12), 32'd0);
      reset = 1'b0;
      tick(2);
      check_mirror("idle_out", 0);

      run_point(1, 2);
      run_point(127, 127);
      run_point(-128, -128);
      for (int i = 0; i < 6; i++) begin
         run_point(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
      end

      // Button held high while switches change: only one capture, WAIT_Y still visited.
      for (int i = 0; i < 21; i++) vals[i] = int'($urandom_range(255)) - 128;
      drive_x(vals[0]);
      Bstus = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         drive_x(vals[i]);
      end
      tick(1);
      check_mirror("hold_cap", vals[2]);
      Bstus = 1'b0;
      tick(4);
      check_mirror("hold_rel", vals[2]);
      finish_point(vals[2], int'($urandom_range(255)) - 128);

      // Sub-cycle glitch between clock edges must not be seen.
      run_point(9, -9);
      tick(1);
      #1;
      drive_x(55);
      Bstus = 1'b1;
      #2;
      Bstus = 1'b0;
      tick(5);
      check_mirror("glitch_hold", -9);
      check("glitch_busy", 32'(busy_s), 32'd0);
      run_point(1, 2);

      // Reset pulse ten cycles into COMPUTE aborts with no result.
      capture_x(5);
      drive_x(7);
      Bstus = 1'b1;
      tick(4);
      Bstus = 1'b0;
      wait_busy(found);
      tick(10);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("abort_out_s", 32'(out_s), 32'd0);
      check("abort_out_w", 32'(out_w), 32'd0);
      check("abort_out_12", 32'(out_12), 32'd0);
      check("abort_busy_s", 32'(busy_s), 32'd0);
      check("abort_busy_12", 32'(busy_12), 32'd0);
      check("abort_done_s", 32'(done_s), 32'd0);
      dones = 0;
      repeat (60) begin
         tick(1);
         if ((done_s | done_w | done_12) !== 1'b0) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      check("abort_out_idle", 32'(out_s), 32'd0);
      run_point(3, -4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
